i2c_regfile: RTL
================

I2C_REGFILE -- requirements
Module: i2c_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: number of 8-bit registers, legal range 2..128.
REQ-002 SHALL have parameter RO_MASK, default 0 (NUM_REGS bits): bit i set makes register i read-only, sourced from reg_in.
REQ-003 SHALL have parameter AUTO_INC, default 1: pointer advances after each data byte written or read.
REQ-004 SHALL have parameter RESET_VAL, default 0 (NUM_REGS*8 bits): per-register reset value.
REQ-005 clk  input  1  system clock; the block has one clock, and reset is asynchronous and active-high.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 i2c_start_stb  input  1  one-cycle pulse: address matched, new transaction begins.
REQ-008 i2c_stop_stb  input  1  one-cycle pulse: STOP or repeated-START seen.
REQ-009 i2c_data_rx  input  8  byte received from master.
REQ-010 i2c_data_rx_valid_stb  input  1  one-cycle pulse: i2c_data_rx valid.
REQ-011 i2c_tx_ack_stb  input  1  one-cycle pulse: master consumed i2c_data_tx and ACKed.
REQ-012 i2c_data_tx  output  8  byte presented to slave for next read.
REQ-013 reg_in  input  NUM_REGS*8  live values for read-only registers.
REQ-014 reg_out  output  NUM_REGS*8  current register contents; read-only slots mirror reg_in.
REQ-015 reg_wr_stb  output  NUM_REGS  one-cycle pulse per register written.
REQ-016 ptr_err  output  1  sticky: out-of-range pointer received.

Function
REQ-017 SHALL implement FSM states IDLE, GET_PTR, DATA.
REQ-018 IDLE -> GET_PTR on i2c_start_stb; GET_PTR -> DATA on first rx byte; any state -> IDLE on i2c_stop_stb.
REQ-019 In GET_PTR, the rx byte SHALL load the pointer (width clog2(NUM_REGS)); byte >= NUM_REGS sets ptr_invalid and ptr_err.
REQ-020 In DATA, each rx byte SHALL write reg[ptr] one cycle after the strobe and pulse reg_wr_stb[ptr] that cycle, unless RO_MASK[ptr] or ptr_invalid.
REQ-021 Dropped writes (read-only or invalid pointer) SHALL NOT pulse reg_wr_stb and SHALL NOT change any register.
REQ-022 i2c_data_tx SHALL combinationally reflect reg_out[ptr], or 8'hFF when ptr_invalid.
REQ-023 i2c_tx_ack_stb SHALL advance the pointer in any state (reads occur from IDLE after repeated START) if AUTO_INC=1.
REQ-024 The pointer SHALL advance after each DATA-state write if AUTO_INC=1; the pointer is held when AUTO_INC=0.
REQ-025 The pointer SHALL wrap from NUM_REGS-1 to 0; ptr_invalid is unchanged by increments.
REQ-026 The pointer and ptr_invalid SHALL persist across STOP so a write-pointer-then-read sequence works.
REQ-027 Simultaneous start and stop: start wins (state GET_PTR).
REQ-028 Simultaneous rx_valid and start/stop: the rx byte is ignored.
REQ-029 Simultaneous rx_valid and tx_ack in DATA: the write uses the old pointer, and the pointer advances once.
REQ-030 ptr_err SHALL clear only on reset.

Reset
REQ-031 On rst: state IDLE, pointer 0, ptr_invalid 0, ptr_err 0, writable registers = RESET_VAL, reg_wr_stb 0, i2c_data_tx = reg_out[0].
REQ-032 Reset asserted mid-transaction SHALL abort it; no partial write is committed.

Structure
REQ-033 Package i2c_regfile_pkg SHALL hold the state enum and a ptr-width constant function.
REQ-034 Single module, no sub-module; the register array is a flat vector indexed by pointer.
REQ-035 Registers are updated only in one clocked process on clk/posedge rst.

Verification
REQ-036 Start, rx 0x02, 0xAA, 0x55 (NUM_REGS=8) -> reg2=0xAA, reg3=0x55, with reg_wr_stb[2] then reg_wr_stb[3].
REQ-037 Start, rx 0x07, 0x11, 0x22 -> reg7=0x11, reg0=0x22 (wrap).
REQ-038 RO_MASK=8'h01, reg_in[7:0]=0x3C; start, rx 0x00, 0x99 -> no reg_wr_stb, reg0 reads 0x3C.
REQ-039 Start, rx 0x09 -> ptr_err=1; data byte dropped; tx=0xFF; ptr_err persists after stop.
REQ-040 Write ptr 0x04, stop, two tx_ack -> tx shows reg4, reg5, then reg6.
REQ-041 Assert rst between pointer byte and data byte -> all registers at RESET_VAL, state IDLE, pointer 0.

Source files
------------

// File: rtl/i2c_regfile_pkg.sv
// Shared types for the I2C-addressed register file: transaction phase enum and pointer sizing.
package i2c_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_PTR = 2'd1,
    ST_DATA    = 2'd2
  } state_t;

  function automatic int ptr_width(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/i2c_regfile.sv
// I2C slave register file: first byte after START sets the pointer, later bytes write reg[ptr].
// Writes land one cycle after the rx strobe; read data is combinational; no backpressure (strobe-driven).
module i2c_regfile
  import i2c_regfile_pkg::*;
#(
  parameter int                    NUM_REGS  = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK   = '0,
  parameter bit                    AUTO_INC  = 1'b1,
  parameter logic [NUM_REGS*8-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_start_stb,
  input  logic                  i2c_stop_stb,
  input  logic [7:0]            i2c_data_rx,
  input  logic                  i2c_data_rx_valid_stb,
  input  logic                  i2c_tx_ack_stb,
  output logic [7:0]            i2c_data_tx,
  input  logic [NUM_REGS*8-1:0] reg_in,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic [NUM_REGS-1:0]   reg_wr_stb,
  output logic                  ptr_err
);

  localparam int             PW       = ptr_width(NUM_REGS);
  localparam logic [PW-1:0]  LAST_PTR = PW'(NUM_REGS - 1);

  state_t                  state;
  logic [PW-1:0]           ptr;
  logic                    ptr_invalid;
  logic [NUM_REGS*8-1:0]   regs;

  logic                    rx_evt;
  logic                    ptr_load;
  logic                    data_byte;
  logic                    ptr_byte_ok;
  logic                    ro_at_ptr;
  logic                    wr_ok;
  logic                    advance;
  logic [PW-1:0]           next_ptr;
  logic [7:0]              tx_sel;

  // A byte arriving alongside START/STOP belongs to no transaction phase.
  assign rx_evt      = i2c_data_rx_valid_stb & ~i2c_start_stb & ~i2c_stop_stb;
  assign ptr_load    = rx_evt & (state == ST_GET_PTR);
  assign data_byte   = rx_evt & (state == ST_DATA);
  assign ptr_byte_ok = ({1'b0, i2c_data_rx} < 9'(NUM_REGS));
  assign wr_ok       = data_byte & ~ptr_invalid & ~ro_at_ptr;
  assign advance     = AUTO_INC & (data_byte | i2c_tx_ack_stb);
  assign next_ptr    = (ptr == LAST_PTR) ? '0 : ptr + 1'b1;

  always_comb begin
    reg_out = regs;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RO_MASK[i]) reg_out[i*8 +: 8] = reg_in[i*8 +: 8];
    end
  end

  // Loop decode keeps out-of-range pointer codes (non power-of-two sizes) harmless.
  always_comb begin
    ro_at_ptr = 1'b0;
    tx_sel    = 8'hFF;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ptr == PW'(i)) begin
        ro_at_ptr = RO_MASK[i];
        tx_sel    = reg_out[i*8 +: 8];
      end
    end
  end

  assign i2c_data_tx = ptr_invalid ? 8'hFF : tx_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      ptr_invalid <= 1'b0;
      ptr_err     <= 1'b0;
      regs        <= RESET_VAL;
      reg_wr_stb  <= '0;
    end else begin
      reg_wr_stb <= '0;

      if (i2c_start_stb)     state <= ST_GET_PTR;
      else if (i2c_stop_stb) state <= ST_IDLE;
      else if (ptr_load)     state <= ST_DATA;

      // Pointer and ptr_invalid deliberately survive STOP for write-pointer-then-read.
      if (ptr_load) begin
        ptr         <= i2c_data_rx[PW-1:0];
        ptr_invalid <= ~ptr_byte_ok;
        if (!ptr_byte_ok) ptr_err <= 1'b1;
      end else if (advance) begin
        ptr <= next_ptr;
      end

      if (wr_ok) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (ptr == PW'(i)) begin
            regs[i*8 +: 8] <= i2c_data_rx;
            reg_wr_stb[i]  <= 1'b1;
          end
        end
      end
    end
  end

endmodule
